// File: rtl/fifo_axisx.sv
// First-word-fall-through AXI4-Stream FIFO: single clock, synchronous active-low reset.
// Outputs are derived only from registered state, so no input-to-output combinational path exists.
module fifo_axisx #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   COUNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] rd_ptr_next;
    logic [AW:0]   count_reg;
    logic [AW:0]   count_next;
    logic          ready_reg;
    logic          ready_next;
    logic          push;
    logic          pop;

    // ready_reg is a registered copy of "not full" so it can also be forced low during reset.
    assign push = s_axis_tvalid && ready_reg;
    assign pop  = m_axis_tvalid && m_axis_tready;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_ONE;
        end
        if (push && !pop) begin
            count_next = count_reg + COUNT_ONE;
        end else if (pop && !push) begin
            count_next = count_reg - COUNT_ONE;
        end
        ready_next = (count_next != FULL_COUNT);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ready_reg  <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            ready_reg  <= ready_next;
        end
    end

    // Storage is deliberately not reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (resetn && push) begin
            mem[wr_ptr_reg] <= s_axis_tdata;
        end
    end

    // A push never targets the head entry while it is valid, so the head word stays stable under backpressure.
    assign s_axis_tready = ready_reg;
    assign m_axis_tvalid = (count_reg != '0);
    assign m_axis_tdata  = m_axis_tvalid ? mem[rd_ptr_reg] : '0;

endmodule

// File: tb/tb_fifo_axisx.sv
// Directed and random stimulus for fifo_axisx with a queue scoreboard of expected output words.
`timescale 1ns/1ps
module tb_fifo_axisx;

    localparam int DW    = 64;
    localparam int DEPTH = 16;

    logic          clk;
    logic          resetn;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] s_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [DW-1:0] m_axis_tdata;

    fifo_axisx #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] sb_q[$];
    logic          mdl_rdy;
    int            checks_total;
    int            checks_passed;
    int            pops_seen;
    int            pushes_seen;
    logic          last_pop;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
        checks_total++;
        assert (obs === exp_v) checks_passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    endtask

    // One clock cycle: drive at negedge, check outputs against the model, then apply the edge to the model.
    task automatic step(input logic rn, input logic sv, input logic [DW-1:0] sd, input logic mr);
        logic          exp_push;
        logic          exp_pop;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
        resetn        = rn;
        s_axis_tvalid = sv;
        s_axis_tdata  = sd;
        m_axis_tready = mr;
        #1;
        exp_valid = (sb_q.size() != 0);
        exp_data  = exp_valid ? sb_q[0] : '0;
        chk("s_axis_tready", {63'd0, s_axis_tready}, {63'd0, mdl_rdy && (sb_q.size() != DEPTH)});
        chk("m_axis_tvalid", {63'd0, m_axis_tvalid}, {63'd0, exp_valid});
        chk("m_axis_tdata", m_axis_tdata, exp_data);
        exp_push = rn && sv && mdl_rdy && (sb_q.size() != DEPTH);
        exp_pop  = rn && mr && exp_valid;
        @(posedge clk);
        last_pop = 1'b0;
        if (!rn) begin
            sb_q.delete();
            mdl_rdy = 1'b0;
        end else begin
            if (exp_pop) begin
                $display("pop  %h", sb_q[0]);
                void'(sb_q.pop_front());
                pops_seen++;
                last_pop = 1'b1;
            end
            if (exp_push) begin
                $display("push %h", sd);
                sb_q.push_back(sd);
                pushes_seen++;
            end
            mdl_rdy = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        int budget;
        checks_total  = 0;
        checks_passed = 0;
        pops_seen     = 0;
        pushes_seen   = 0;
        mdl_rdy       = 1'b0;
        last_pop      = 1'b0;
        resetn        = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b0;

        // Reset: first edge brings the DUT out of X, then three checked reset cycles.
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 64'hFFFF, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0);
        chk("ready_after_release", {63'd0, s_axis_tready}, 64'd1);
        chk("valid_after_release", {63'd0, m_axis_tvalid}, 64'd0);

        // Single word held under backpressure, then popped.
        step(1'b1, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("single_hold_data", m_axis_tdata, 64'h0123_4567_89AB_CDEF);
            step(1'b1, 1'b0, '0, 1'b0);
        end
        step(1'b1, 1'b0, '0, 1'b1);
        chk("single_popped", {63'd0, last_pop}, 64'd1);
        chk("single_valid_low", {63'd0, m_axis_tvalid}, 64'd0);

        // Fill to full, offer a rejected 17th word, pop one, refill, drain.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 64'(i), 1'b0);
        chk("full_ready_low", {63'd0, s_axis_tready}, 64'd0);
        step(1'b1, 1'b1, 64'h17, 1'b0);
        step(1'b1, 1'b1, 64'h18, 1'b1);
        chk("ready_after_pop", {63'd0, s_axis_tready}, 64'd1);
        step(1'b1, 1'b1, 64'd16, 1'b0);
        chk("refull_ready_low", {63'd0, s_axis_tready}, 64'd0);
        budget = 0;
        while (sb_q.size() != 0 && budget < 40) begin
            step(1'b1, 1'b0, '0, 1'b1);
            budget++;
        end
        chk("drain_done", 64'(sb_q.size()), 64'd0);

        // Streaming: one word per cycle with both sides always ready.
        step(1'b1, 1'b1, 64'h1000, 1'b1);
        for (int i = 1; i < 100; i++) begin
            step(1'b1, 1'b1, 64'h1000 + 64'(i), 1'b1);
            chk("stream_pop_each_cycle", {63'd0, last_pop}, 64'd1);
        end
        step(1'b1, 1'b0, '0, 1'b1);
        chk("stream_empty", {63'd0, m_axis_tvalid}, 64'd0);

        // Random valid/ready at 50% until 1000 words have been accepted, then drain.
        pushes_seen = 0;
        pops_seen   = 0;
        budget      = 0;
        while (pushes_seen < 1000 && budget < 20000) begin
            step(1'b1, 1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
            budget++;
        end
        chk("random_push_budget", 64'(pushes_seen), 64'd1000);
        budget = 0;
        while (sb_q.size() != 0 && budget < 100) begin
            step(1'b1, 1'b0, '0, 1'b1);
            budget++;
        end
        chk("random_all_delivered", 64'(pops_seen), 64'd1000);

        // Mid-stream reset with seven words buffered.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 64'hA0 + 64'(i), 1'b0);
        chk("seven_buffered", 64'(sb_q.size()), 64'd7);
        step(1'b0, 1'b1, 64'hBAD, 1'b0);
        chk("post_reset_valid", {63'd0, m_axis_tvalid}, 64'd0);
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 64'hDEAD_BEEF, 1'b0);
        chk("new_word_first", m_axis_tdata, 64'hDEAD_BEEF);
        step(1'b1, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b1);
        chk("post_reset_drained", {63'd0, m_axis_tvalid}, 64'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
